// File: rtl/uart_txrx_sched_if.sv
// Byte-stream and simpleuart register-port signals of the UART TX/RX sequencer.
// The sequencer takes the slave modport; the driving environment takes master.
interface uart_txrx_sched_if #(
  parameter int unsigned TX_DEPTH = 8
);
  localparam int unsigned LW = $clog2(TX_DEPTH) + 1;

  logic          tx_valid;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic [LW-1:0] tx_level;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          div_valid;
  logic [31:0]   div_value;
  logic          busy;
  logic [3:0]    reg_div_we;
  logic [31:0]   reg_div_di;
  logic          reg_dat_we;
  logic          reg_dat_re;
  logic [31:0]   reg_dat_di;
  logic [31:0]   reg_dat_do;
  logic          reg_dat_wait;

  modport slave (
    input  tx_valid, tx_data, rx_ready, div_valid, div_value, reg_dat_do, reg_dat_wait,
    output tx_ready, tx_level, rx_valid, rx_data, busy, reg_div_we, reg_div_di, reg_dat_we,
           reg_dat_re, reg_dat_di
  );

  modport master (
    output tx_valid, tx_data, rx_ready, div_valid, div_value, reg_dat_do, reg_dat_wait,
    input  tx_ready, tx_level, rx_valid, rx_data, busy, reg_div_we, reg_div_di, reg_dat_we,
           reg_dat_re, reg_dat_di
  );
endinterface

// File: rtl/uart_txrx_sched.sv
// Sequencer/arbiter in front of simpleuart: buffers TX bytes, drains them through reg_dat_we,
// polls RX through reg_dat_re and owns all divider writes. All register-port strobes are flops.
module uart_txrx_sched #(
  parameter int unsigned TX_DEPTH    = 8,
  parameter logic [31:0] DEFAULT_DIV = 32'd104,
  parameter logic [31:0] NO_DATA     = 32'hFFFF_FFFF
) (
  input logic              clk,
  input logic              resetn,
  uart_txrx_sched_if.slave bus
);
  localparam int unsigned AW = $clog2(TX_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] Full = LW'(TX_DEPTH);

  typedef enum logic [2:0] {StInitDiv, StIdle, StDivWr, StTxWr, StRxRd} state_e;

  state_e        state_q, state_d;
  logic [7:0]    mem_q [TX_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          div_pend_q, div_pend_d;
  logic [31:0]   div_pend_val_q;
  logic          last_rx_q, last_rx_d;  // 1: most recent grant went to RX
  logic          rx_valid_q;
  logic [7:0]    rx_data_q;
  logic [3:0]    div_we_q;
  logic [31:0]   div_di_q;
  logic          dat_we_q, dat_re_q;
  logic [31:0]   dat_di_q;
  logic          busy_q;
  logic          push, pop, tx_elig, rx_elig;

  assign push    = bus.tx_valid && (level_q != Full);
  assign pop     = (state_q == StTxWr) && !bus.reg_dat_wait;
  assign tx_elig = (level_q != '0);
  assign rx_elig = !rx_valid_q;

  always_comb begin
    state_d   = state_q;
    last_rx_d = last_rx_q;
    unique case (state_q)
      // Stay one extra cycle so the registered divider strobe is seen after reset release.
      StInitDiv: if (div_we_q != 4'h0) state_d = StIdle;
      StIdle: begin
        if (div_pend_q) begin
          state_d = StDivWr;
        end else if (tx_elig && (!rx_elig || last_rx_q)) begin
          state_d   = StTxWr;
          last_rx_d = 1'b0;
        end else if (rx_elig) begin
          state_d   = StRxRd;
          last_rx_d = 1'b1;
        end
      end
      StTxWr:          if (!bus.reg_dat_wait) state_d = StIdle;
      StDivWr, StRxRd: state_d = StIdle;
      default:         state_d = StInitDiv;
    endcase
  end

  always_comb begin
    div_pend_d = div_pend_q;
    // Cleared at grant so a pulse arriving during the grant cycle is not lost.
    if ((state_q == StIdle) && div_pend_q) div_pend_d = 1'b0;
    if (bus.div_valid) div_pend_d = 1'b1;
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StInitDiv;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      div_pend_q     <= 1'b0;
      div_pend_val_q <= '0;
      last_rx_q      <= 1'b1;
      rx_valid_q     <= 1'b0;
      rx_data_q      <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      div_pend_q <= div_pend_d;
      last_rx_q  <= last_rx_d;
      busy_q     <= (state_d != StIdle) || (level_d != '0) || div_pend_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (bus.div_valid) div_pend_val_q <= bus.div_value;
      if ((state_q == StRxRd) && (bus.reg_dat_do != NO_DATA)) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= bus.reg_dat_do[7:0];
      end else if (bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  // Strobes are loaded from the state being entered, so they line up with state_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_we_q <= '0;
      div_di_q <= '0;
      dat_we_q <= 1'b0;
      dat_re_q <= 1'b0;
      dat_di_q <= '0;
    end else begin
      div_we_q <= '0;
      div_di_q <= '0;
      dat_we_q <= 1'b0;
      dat_re_q <= 1'b0;
      dat_di_q <= '0;
      unique case (state_d)
        StInitDiv: begin
          div_we_q <= 4'hF;
          div_di_q <= DEFAULT_DIV;
        end
        StDivWr: begin
          div_we_q <= 4'hF;
          div_di_q <= div_pend_val_q;
        end
        StTxWr: begin
          dat_we_q <= 1'b1;
          dat_di_q <= {24'h0, mem_q[rd_ptr_q]};
        end
        StRxRd:  dat_re_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.tx_ready   = (level_q != Full);
  assign bus.tx_level   = level_q;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_data    = rx_data_q;
  assign bus.busy       = busy_q;
  assign bus.reg_div_we = div_we_q;
  assign bus.reg_div_di = div_di_q;
  assign bus.reg_dat_we = dat_we_q;
  assign bus.reg_dat_re = dat_re_q;
  assign bus.reg_dat_di = dat_di_q;
endmodule

// File: tb/tb_uart_txrx_sched.sv
// Directed bench for uart_txrx_sched: divider init, TX draining with back-pressure, FIFO full,
// TX/RX round-robin, RX hold, runtime divider update and mid-burst reset.
module tb_uart_txrx_sched;
  localparam logic [31:0] NoData = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Observation logs, written only by the monitor.
  logic [7:0] tx_log[$];
  bit         grant_log[$];  // 0: TX grant, 1: RX poll
  int         we_hi_cnt = 0;
  int         div_we_cnt = 0;
  int         re_cnt = 0;
  int         re_bad_cnt = 0;
  int         we_rise_cnt = 0;
  logic       we_prev = 1'b0;

  int base_log, base_cnt, gb, idx;

  uart_txrx_sched_if #(.TX_DEPTH(8)) bus ();

  uart_txrx_sched #(
    .TX_DEPTH   (8),
    .DEFAULT_DIV(32'd104),
    .NO_DATA    (NoData)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.reg_dat_we && !bus.reg_dat_wait) tx_log.push_back(bus.reg_dat_di[7:0]);
    if (bus.reg_dat_we) we_hi_cnt++;
    if (bus.reg_dat_we && !we_prev) we_rise_cnt++;
    if (bus.reg_div_we != 4'h0) div_we_cnt++;
    if (bus.reg_dat_re) re_cnt++;
    if (bus.reg_dat_re && bus.rx_valid) re_bad_cnt++;
    if (bus.reg_dat_re) grant_log.push_back(1'b1);
    else if (bus.reg_dat_we && !we_prev) grant_log.push_back(1'b0);
    we_prev = bus.reg_dat_we;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the byte has been taken.
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = b;
    @(negedge clk);
    while (!bus.tx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val("push_timeout", 32'(n >= 500), 32'd0);
    @(posedge clk);
    #1;
    bus.tx_valid = 1'b0;
  endtask

  // sel: 0 reg_dat_we, 1 rx_valid, 2 reg_div_we, 3 tx_log size >= arg. Returns at a negedge.
  task automatic wait_for(input string tag, input int sel, input int arg);
    bit hit = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      case (sel)
        0:       hit = bus.reg_dat_we;
        1:       hit = bus.rx_valid;
        2:       hit = (bus.reg_div_we != 4'h0);
        default: hit = (tx_log.size() >= arg);
      endcase
      if (hit) break;
    end
    check_val({tag, "_timeout"}, 32'(hit), 32'd1);
  endtask

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    bus.rx_ready = 1'b0;
    bus.div_valid = 1'b0;
    bus.div_value = 32'h0;
    bus.reg_dat_do = NoData;
    bus.reg_dat_wait = 1'b0;

    // Reset values, then the single default divider write
    @(negedge clk);
    check_val("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
    check_val("rst_tx_level", 32'(bus.tx_level), 32'd0);
    check_val("rst_div_we", 32'(bus.reg_div_we), 32'd0);
    check_val("rst_dat_we", 32'(bus.reg_dat_we), 32'd0);
    check_val("rst_dat_re", 32'(bus.reg_dat_re), 32'd0);
    check_val("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    tick(2);
    resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("init_div_we", 32'(bus.reg_div_we), 32'hF);
    check_val("init_div_di", bus.reg_div_di, 32'd104);
    check_val("init_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check_val("init_div_we_off", 32'(bus.reg_div_we), 32'd0);
    tick(5);
    check_val("init_div_count", 32'(div_we_cnt), 32'd1);

    // Three bytes, no back-pressure
    base_log = tx_log.size();
    base_cnt = we_rise_cnt;
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    wait_for("tx3", 3, base_log + 3);
    tick(10);
    check_val("tx3_b0", 32'(tx_log[base_log]), 32'h41);
    check_val("tx3_b1", 32'(tx_log[base_log + 1]), 32'h42);
    check_val("tx3_b2", 32'(tx_log[base_log + 2]), 32'h43);
    check_val("tx3_pulses", 32'(we_rise_cnt - base_cnt), 32'd3);
    check_val("tx3_level", 32'(bus.tx_level), 32'd0);

    // One byte held off by reg_dat_wait for 20 cycles
    bus.reg_dat_wait = 1'b1;
    base_log = tx_log.size();
    base_cnt = we_hi_cnt;
    push_byte(8'h55);
    wait_for("hold_we", 0, 0);
    check_val("hold_level1", 32'(bus.tx_level), 32'd1);
    check_val("hold_di", bus.reg_dat_di, 32'h55);
    repeat (19) @(negedge clk);
    check_val("hold_still_level1", 32'(bus.tx_level), 32'd1);
    @(posedge clk);
    #1;
    bus.reg_dat_wait = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("hold_level0", 32'(bus.tx_level), 32'd0);
    check_val("hold_we_off", 32'(bus.reg_dat_we), 32'd0);
    check_val("hold_we_cycles", 32'(we_hi_cnt - base_cnt), 32'd21);
    check_val("hold_pops", 32'(tx_log.size() - base_log), 32'd1);
    check_val("hold_byte", 32'(tx_log[base_log]), 32'h55);

    // Fill the FIFO under back-pressure; ninth byte must wait
    tick(1);
    bus.reg_dat_wait = 1'b1;
    base_log = tx_log.size();
    for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h18;
    @(negedge clk);
    check_val("full_level", 32'(bus.tx_level), 32'd8);
    check_val("full_ready", 32'(bus.tx_ready), 32'd0);
    repeat (5) @(negedge clk);
    check_val("full_level_held", 32'(bus.tx_level), 32'd8);
    check_val("full_ready_held", 32'(bus.tx_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.reg_dat_wait = 1'b0;
    push_byte(8'h18);
    wait_for("full_drain", 3, base_log + 9);
    for (int i = 0; i < 9; i++)
      check_val($sformatf("full_b%0d", i), 32'(tx_log[base_log + i]), 32'(8'h10 + i));

    // Round-robin with NO_DATA polls, then a held RX byte
    tick(10);
    base_log = tx_log.size();
    gb = grant_log.size();
    push_byte(8'h21);
    push_byte(8'h22);
    push_byte(8'h23);
    push_byte(8'h24);
    wait_for("rr_tx", 3, base_log + 4);
    tick(6);
    idx = -1;
    for (int i = gb; i < grant_log.size(); i++)
      if (!grant_log[i]) begin
        idx = i;
        break;
      end
    check_val("rr_tx_seen", 32'(idx >= 0), 32'd1);
    if (idx >= 0)
      for (int k = 0; k < 7; k++)
        check_val($sformatf("rr_grant%0d", k),
                  (idx + k < grant_log.size()) ? 32'(grant_log[idx + k]) : 32'hEE, 32'(k % 2));
    check_val("rr_nodata_rx_valid", 32'(bus.rx_valid), 32'd0);

    bus.reg_dat_do = 32'h0000_005A;
    wait_for("rx_valid", 1, 0);
    check_val("rx_data", 32'(bus.rx_data), 32'h5A);
    base_cnt = re_cnt;
    repeat (10) @(negedge clk);
    check_val("rx_hold_valid", 32'(bus.rx_valid), 32'd1);
    check_val("rx_hold_data", 32'(bus.rx_data), 32'h5A);
    check_val("rx_no_poll", 32'(re_cnt - base_cnt), 32'd0);
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b1;
    bus.reg_dat_do = NoData;
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    @(negedge clk);
    check_val("rx_taken", 32'(bus.rx_valid), 32'd0);

    // Divider update requested mid-byte is applied after the byte
    tick(3);
    bus.reg_dat_wait = 1'b1;
    push_byte(8'h77);
    wait_for("div_tx_we", 0, 0);
    base_cnt = div_we_cnt;
    @(posedge clk);
    #1;
    bus.div_valid = 1'b1;
    bus.div_value = 32'h1B2;
    @(posedge clk);
    #1;
    bus.div_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_val("div_deferred", 32'(div_we_cnt - base_cnt), 32'd0);
    check_val("div_tx_held", 32'(bus.reg_dat_we), 32'd1);
    @(posedge clk);
    #1;
    bus.reg_dat_wait = 1'b0;
    wait_for("div_wr", 2, 0);
    check_val("div_wr_di", bus.reg_div_di, 32'h1B2);
    check_val("div_after_byte", 32'(tx_log[tx_log.size() - 1]), 32'h77);
    @(negedge clk);
    check_val("div_wr_one_cycle", 32'(bus.reg_div_we), 32'd0);
    check_val("div_count", 32'(div_we_cnt - base_cnt), 32'd1);

    // Reset in the middle of a stalled burst with an RX byte held
    tick(1);
    bus.reg_dat_do = 32'h0000_0033;
    wait_for("rst_rx", 1, 0);
    @(posedge clk);
    #1;
    bus.reg_dat_do = NoData;
    bus.reg_dat_wait = 1'b1;
    push_byte(8'h81);
    push_byte(8'h82);
    push_byte(8'h83);
    @(negedge clk);
    check_val("pre_rst_level", 32'(bus.tx_level), 32'd3);
    check_val("pre_rst_rx_valid", 32'(bus.rx_valid), 32'd1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    check_val("mid_rst_level", 32'(bus.tx_level), 32'd0);
    check_val("mid_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_val("mid_rst_ready", 32'(bus.tx_ready), 32'd1);
    check_val("mid_rst_we", 32'(bus.reg_dat_we), 32'd0);
    base_log = tx_log.size();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    bus.reg_dat_wait = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("reinit_div_we", 32'(bus.reg_div_we), 32'hF);
    check_val("reinit_div_di", bus.reg_div_di, 32'd104);
    @(negedge clk);
    check_val("reinit_div_off", 32'(bus.reg_div_we), 32'd0);
    tick(20);
    check_val("flushed_no_tx", 32'(tx_log.size() - base_log), 32'd0);
    check_val("flushed_level", 32'(bus.tx_level), 32'd0);
    check_val("no_poll_while_valid", 32'(re_bad_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
